// File: rtl/logic_4099.sv
`default_nettype none
// ============================================================================
// Module   : logic_4099
// Purpose  : Cycle-based emulation of the CMOS 4099 8-bit addressable latch.
//            Asynchronous board pins are synchronized, then decoded each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module logic_4099 #(
    parameter int ADDR_W      = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   D,
    input  logic                   WD,
    input  logic                   RESET,
    input  logic [ADDR_W-1:0]      A,
    output logic [2**ADDR_W-1:0]   Q
);

    localparam int c_IN_W  = ADDR_W + 3;
    localparam int c_NUM_Q = 2**ADDR_W;

    logic [c_IN_W-1:0]  w_pins;
    logic [c_IN_W-1:0]  w_samp;
    logic               w_s_reset;
    logic               w_s_wd;
    logic               w_s_d;
    logic [ADDR_W-1:0]  w_s_a;
    logic [c_NUM_Q-1:0] w_q_next;
    logic [c_NUM_Q-1:0] r_q;

    // All pins share one pipeline so they remain mutually aligned.
    assign w_pins = {RESET, WD, D, A};

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign w_samp = w_pins;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0][c_IN_W-1:0] r_sync;

            always_ff @(posedge CLK) begin
                if (RST) begin
                    r_sync <= '0;
                end else begin
                    r_sync[0] <= w_pins;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        r_sync[i] <= r_sync[i-1];
                    end
                end
            end

            assign w_samp = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    assign w_s_reset = w_samp[c_IN_W-1];
    assign w_s_wd    = w_samp[c_IN_W-2];
    assign w_s_d     = w_samp[ADDR_W];
    assign w_s_a     = w_samp[ADDR_W-1:0];

    // Mode is re-decoded every cycle; only Q carries state.
    always_comb begin
        w_q_next = r_q;
        case ({w_s_reset, w_s_wd})
            2'b00: begin
                w_q_next[w_s_a] = w_s_d;
            end
            2'b01: begin
                w_q_next = r_q;
            end
            2'b10: begin
                w_q_next        = '0;
                w_q_next[w_s_a] = w_s_d;
            end
            default: begin
                w_q_next = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_q <= '0;
        end else begin
            r_q <= w_q_next;
        end
    end

    assign Q = r_q;

endmodule
`default_nettype wire

// File: tb/tb_logic_4099.sv
`default_nettype none
// ============================================================================
// Module   : tb_logic_4099
// Purpose  : Self-checking bench for logic_4099 across four parameter sets.
// Revision : 1.0 - initial release
// ============================================================================
module tb_logic_4099;

    logic       clk = 1'b0;
    logic       rst;
    logic       d;
    logic       wd;
    logic       reset_pin;
    logic [2:0] a;
    logic [7:0] q0;
    logic [7:0] q1;
    logic [7:0] q2;
    logic [3:0] q3;

    int n_assert = 0;
    int n_fail   = 0;

    // Instance parameter sets: {SYNC_STAGES, ADDR_W}
    int ss_of [4] = '{2, 0, 3, 2};
    int aw_of [4] = '{3, 3, 3, 2};

    logic [5:0] hist [4][3];
    logic [7:0] qm   [4];

    always #5 clk = ~clk;

    logic_4099 #(.ADDR_W(3), .SYNC_STAGES(2)) u_dut0 (
        .CLK(clk), .RST(rst), .D(d), .WD(wd), .RESET(reset_pin), .A(a), .Q(q0));
    logic_4099 #(.ADDR_W(3), .SYNC_STAGES(0)) u_dut1 (
        .CLK(clk), .RST(rst), .D(d), .WD(wd), .RESET(reset_pin), .A(a), .Q(q1));
    logic_4099 #(.ADDR_W(3), .SYNC_STAGES(3)) u_dut2 (
        .CLK(clk), .RST(rst), .D(d), .WD(wd), .RESET(reset_pin), .A(a), .Q(q2));
    logic_4099 #(.ADDR_W(2), .SYNC_STAGES(2)) u_dut3 (
        .CLK(clk), .RST(rst), .D(d), .WD(wd), .RESET(reset_pin), .A(a[1:0]), .Q(q3));

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    // Reference: pins seen ss edges ago, then the four-mode rule table.
    task automatic model_edge(input int n);
        logic [5:0] pins;
        logic [5:0] samp;
        logic [7:0] one;
        logic [7:0] mask;
        int         ss;
        int         adr;
        ss   = ss_of[n];
        pins = {reset_pin, wd, d, a};
        if (rst) begin
            for (int i = 0; i < 3; i++) hist[n][i] = 6'd0;
            qm[n] = 8'h00;
            return;
        end
        if (ss == 0) begin
            samp = pins;
        end else begin
            samp = hist[n][ss-1];
            for (int i = ss - 1; i > 0; i--) hist[n][i] = hist[n][i-1];
            hist[n][0] = pins;
        end
        adr  = int'(samp[2:0]) % (1 << aw_of[n]);
        one  = 8'(1 << adr);
        mask = 8'((1 << (1 << aw_of[n])) - 1);
        case (samp[5:4])
            2'b00:   qm[n] = samp[3] ? (qm[n] | one) : (qm[n] & ~one);
            2'b01:   qm[n] = qm[n];
            2'b10:   qm[n] = samp[3] ? one : 8'h00;
            default: qm[n] = 8'h00;
        endcase
        qm[n] = qm[n] & mask;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        for (int n = 0; n < 4; n++) model_edge(n);
        #1;
        check({tag, " ss2"},     q0,         qm[0]);
        check({tag, " ss0"},     q1,         qm[1]);
        check({tag, " ss3"},     q2,         qm[2]);
        check({tag, " aw2"},     {4'h0, q3}, qm[3]);
    endtask

    task automatic set_pins(input logic r, input logic w, input logic dd, input logic [2:0] aa);
        reset_pin = r;
        wd        = w;
        d         = dd;
        a         = aa;
    endtask

    initial begin
        for (int n = 0; n < 4; n++) begin
            qm[n] = 8'h00;
            for (int i = 0; i < 3; i++) hist[n][i] = 6'd0;
        end
        rst = 1'b1;
        set_pins(1'b0, 1'b0, 1'b1, 3'd5);

        // System reset overrides an active latch write
        step("rst");
        check("rst hold 1", q0, 8'h00);
        step("rst");
        check("rst hold 2", q0, 8'h00);
        rst = 1'b0;
        step("post rst");
        check("post rst e1", q0, 8'h00);
        step("post rst");
        check("post rst e2", q0, 8'h00);
        step("post rst");
        check("post rst e3", q0, 8'h20);

        // Addressable latch: A=0,3,7 with D=1, four cycles each
        rst = 1'b1;
        set_pins(1'b0, 1'b0, 1'b1, 3'd0);
        step("latch rst");
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) step("latch a0");
        check("latch a0", q0, 8'h01);
        a = 3'd3;
        step("latch a3");
        step("latch a3");
        check("latch a3 e2", q0, 8'h01);
        step("latch a3");
        check("latch a3 e3", q0, 8'h09);
        step("latch a3");
        a = 3'd7;
        for (int k = 1; k <= 4; k++) step("latch a7");
        check("latch a7", q0, 8'h89);

        // Memory: pins toggle freely, Q frozen
        for (int k = 0; k < 12; k++) begin
            set_pins(1'b0, 1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
            step("memory");
            check("memory hold", q0, 8'h89);
        end

        // Demux
        set_pins(1'b1, 1'b0, 1'b1, 3'd2);
        step("demux");
        step("demux");
        check("demux a2 e2", q0, 8'h89);
        step("demux");
        check("demux a2 e3", q0, 8'h04);
        d = 1'b0;
        for (int k = 1; k <= 3; k++) step("demux d0");
        check("demux d0", q0, 8'h00);
        set_pins(1'b1, 1'b0, 1'b1, 3'd6);
        for (int k = 1; k <= 3; k++) step("demux a6");
        check("demux a6", q0, 8'h40);

        // Fill all ones, then a one-cycle CLEAR pulse
        for (int k = 0; k < 8; k++) begin
            set_pins(1'b0, 1'b0, 1'b1, 3'(k));
            step("fill");
        end
        set_pins(1'b0, 1'b1, 1'b0, 3'd0);
        for (int k = 1; k <= 3; k++) step("fill hold");
        check("fill ff", q0, 8'hFF);
        set_pins(1'b1, 1'b1, 1'b0, 3'd0);
        step("clear");
        check("clear e1", q0, 8'hFF);
        reset_pin = 1'b0;
        step("clear");
        check("clear e2", q0, 8'hFF);
        step("clear");
        check("clear e3", q0, 8'h00);
        step("clear");
        check("clear e4", q0, 8'h00);
        step("clear");
        check("clear e5", q0, 8'h00);

        // Address hazard on the unsynchronized instance
        rst = 1'b1;
        step("hazard rst");
        rst = 1'b0;
        set_pins(1'b0, 1'b0, 1'b1, 3'd1);
        step("hazard");
        a = 3'd3;
        step("hazard");
        a = 3'd2;
        step("hazard");
        check("hazard wd0", q1, 8'h0E);
        wd = 1'b1;
        step("hazard");
        rst = 1'b1;
        step("hazard rst");
        rst = 1'b0;
        set_pins(1'b0, 1'b0, 1'b1, 3'd1);
        step("hazard");
        set_pins(1'b0, 1'b1, 1'b1, 3'd3);
        step("hazard");
        set_pins(1'b0, 1'b0, 1'b1, 3'd2);
        step("hazard");
        check("hazard wd1", q1, 8'h06);
        wd = 1'b1;
        for (int k = 0; k < 4; k++) step("hazard flush");

        // Mid-operation reset in DEMUX mode
        set_pins(1'b1, 1'b0, 1'b1, 3'd4);
        for (int k = 0; k < 4; k++) step("mid demux");
        check("mid demux", q0, 8'h10);
        rst = 1'b1;
        step("mid rst");
        check("mid rst", q0, 8'h00);
        rst = 1'b0;
        step("mid refill");
        step("mid refill");
        check("mid refill e2", q0, 8'h00);
        step("mid refill");
        check("mid refill e3", q0, 8'h10);

        // Randomized traffic with occasional system reset
        for (int k = 0; k < 300; k++) begin
            rst = ($urandom_range(0, 31) == 0);
            set_pins(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
            step("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/logic_4099.md
Name: logic_4099

Overview:
- Cycle-based emulation of the CMOS 4099 8-bit addressable latch.
- It is the inverse of the 3-channel analog multiplexer model: one data input is steered by a binary address to one of 2**ADDR_W latched outputs.
- Sits in the logic-chip library of the TTL/CMOS emulator. Its pins are driven from emulated board nets, which are asynchronous to CLK.
- Pins are sampled every CLK, and latch behaviour is reproduced synchronously.

Parameters:
- ADDR_W, 3: address width; the output count is 2**ADDR_W (8 for a real 4099).
- SYNC_STAGES, 2: flop stages on every pin input (D, WD, RESET, A). Legal range 0..3; 0 means pins are used directly.

Ports:
- CLK, input, 1: emulator system clock; all state changes on its rising edge.
- RST, input, 1: system reset, synchronous, active-high. This is not the chip's reset pin.
- D, input, 1: chip data pin.
- WD, input, 1: chip WRITE DISABLE pin, active-high.
- RESET, input, 1: chip RESET pin, active-high. Its function depends on WD (see Behaviour).
- A, input, ADDR_W: chip address pins A0..A(n-1); A[0] is the LSB.
- Q, output, 2**ADDR_W: latched outputs; Q[k] is chip pin Qk.

Behaviour:
- Clocking: one clock (CLK); reset is synchronous and active-high (RST). No asynchronous paths.
- RST=1 at a rising edge:
  - All Q bits go to 0.
  - All synchronizer flops go to 0, which corresponds to the sampled state WD=0, RESET=0, D=0, A=0.
  - RST overrides all pin activity.
- Input stage:
  - D, WD, RESET and A each pass through SYNC_STAGES flops. The resulting sampled values are sD, sWD, sRESET and sA.
  - All four pins use the same stage count, so they stay mutually aligned.
- Mode decode, evaluated every cycle from the sampled values, with Q updated at the next rising edge:
  - sRESET=0, sWD=0 (ADDRESSABLE LATCH): Q[sA] <= sD; all other Q bits hold.
  - sRESET=0, sWD=1 (MEMORY): all Q bits hold.
  - sRESET=1, sWD=0 (DEMUX): Q[sA] <= sD; all other Q bits <= 0.
  - sRESET=1, sWD=1 (CLEAR): all Q bits <= 0.
- Latency: a pin change appears on Q exactly SYNC_STAGES+1 CLK edges after it is first sampled.
- The Q register is the only architectural state. No hidden mode state carries over between cycles: the mode is re-decoded every cycle.
- Address changes while in ADDRESSABLE LATCH mode:
  - Every cycle writes sD to the address sampled in that cycle.
  - Intermediate addresses seen during a multi-bit address change are therefore written. This is the intended emulation of the real chip's transparent-latch hazard.
  - Board logic must hold WD=1 across address changes.
- Leaving a write mode: going from latch mode to MEMORY freezes the value written in the last write cycle.
- CLEAR followed by a write mode: Q is 0 for the CLEAR cycles, then the addressed bit follows D.
- Simultaneous RST=1 and any pin mode: RST wins; Q=0.
- Width rule: sA is always in range (0..2**ADDR_W-1), so no out-of-range handling is needed.
- Q never goes X: no X or Z values are produced. Undriven inputs are the caller's responsibility.

Test Plan:
- Reset: assert RST for 2 cycles with D=1, WD=0, A=5 → Q=8'h00 for the whole time RST is held. First post-reset write appears SYNC_STAGES+1 edges after release.
- Addressable latch (SYNC_STAGES=2): with WD=0, RESET=0, write D=1 to A=0,3,7 in turn, each held for 4 cycles. Then set WD=1 and toggle D and A freely → Q=8'h89, unchanged during MEMORY. Each bit rises exactly 3 edges after its pin change.
- Demux: start from Q=8'h89, set RESET=1, WD=0, A=2, D=1 → Q=8'h04 after 3 edges. Then set D=0 → Q=8'h00. Then A=6, D=1 → Q=8'h40.
- Clear: start from Q=8'hFF, pulse RESET=1 with WD=1 for 1 cycle → Q=8'h00 for exactly 1 cycle after latency. Then restore WD=1, RESET=0 → Q stays 8'h00.
- Address-hazard emulation, SYNC_STAGES=0:
  - With WD=0, D=1, step A 1→2 over one intermediate cycle at A=3 → Q bits 1, 3 and 2 are all set (Q=8'h0E).
  - Repeat with WD=1 during the transition → only bits 1 and 2 are set.
- Mid-operation reset plus parameter sweep:
  - In DEMUX mode with Q=8'h10, assert RST for 1 cycle → Q=8'h00 on that edge. Outputs resume per mode after the pipeline refills.
  - Repeat all of the above with SYNC_STAGES=0 and 3, and with ADDR_W=2.
